mobo_responder: RTL

- Motherboard-side bus target that answers the CPU's memory-mapped requests.
- Decodes `mobo_ctrl`, `addr` and `data_out` from the CPU, and returns `mobo_stat` and `data_in` over a 4-phase req/ack handshake with configurable wait states.
- Contains a word-addressed frame buffer that the CPU writes and the VGA scan-out reads through an independent pixel read port.
- Also exposes a read-only write-count register.

---
 rtl/mobo_responder_if.sv | 25 ++
 rtl/mobo_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mobo_responder_if.sv
// CPU <-> motherboard request/response bus.
//   mobo_ctrl : CPU -> target, bit0 = req, bit1 = we
//   mobo_stat : target -> CPU, bit0 = ack, bit1 = busy, bit2 = err
//   addr      : CPU -> target, word address
//   data_out  : CPU -> target, write data
//   data_in   : target -> CPU, read data
interface mobo_responder_if #(
  parameter int unsigned word_width = 32
);
  logic [word_width-1:0] mobo_ctrl;
  logic [word_width-1:0] mobo_stat;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] data_out;
  logic [word_width-1:0] data_in;

  modport master (
    output mobo_ctrl, addr, data_out,
    input  mobo_stat, data_in
  );

  modport slave (
    input  mobo_ctrl, addr, data_out,
    output mobo_stat, data_in
  );
endinterface

// File: rtl/mobo_responder.sv
// Motherboard-side bus target: answers CPU requests over a 4-phase req/ack
// handshake with configurable wait states, hosts a word-addressed frame
// buffer with an independent VGA read port, and a read-only write counter.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-low reset
//   bus      : CPU request/response bus (slave side)
//   pix_addr : VGA frame-buffer index
//   pix_data : VGA read data, 1-cycle latency
module mobo_responder #(
  parameter int unsigned           word_width  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter int unsigned           ADDR_BITS   = 8,
  parameter logic [word_width-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned           WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mobo_responder_if.slave       bus,
  input  logic [ADDR_BITS-1:0]  pix_addr,
  output logic [word_width-1:0] pix_data
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_next;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] wdata_q;
  logic                  we_q;
  logic [word_width-1:0] wcount_q;
  logic [word_width-1:0] stat_q;
  logic [word_width-1:0] stat_next;
  logic [word_width-1:0] data_in_q;
  logic [word_width-1:0] data_in_next;

  logic [word_width-1:0] mem [DEPTH];

  logic                  req;
  logic                  we;
  logic                  latch;
  logic                  commit;
  logic [word_width-1:0] offset;
  logic                  fb_hit;
  logic                  wc_hit;
  logic [ADDR_BITS-1:0]  fb_idx;
  logic                  fb_we;
  logic                  err;
  logic [word_width-1:0] rd_data;

  assign req = bus.mobo_ctrl[0];
  assign we  = bus.mobo_ctrl[1];

  // Upper control bits carry no meaning for this target.
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, bus.mobo_ctrl[word_width-1:2]};

  // Address decode on the latched address; addresses below the base wrap
  // to a large offset and fall into the unmapped region.
  assign offset = addr_q - BASE_ADDR;
  assign fb_hit = offset < word_width'(DEPTH);
  assign wc_hit = offset == word_width'(DEPTH);
  assign fb_idx = offset[ADDR_BITS-1:0];

  assign latch  = (state == ST_IDLE) && req;
  assign commit = (state == ST_WAIT) && (cnt_q == '0);
  assign fb_we  = commit && we_q && fb_hit;
  assign err    = !fb_hit && !(wc_hit && !we_q);

  always_comb begin
    rd_data = '0;
    if (fb_hit) begin
      rd_data = mem[fb_idx];
    end else if (wc_hit) begin
      rd_data = wcount_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (req) next_state = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) next_state = req ? ST_ACK : ST_IDLE;
      ST_ACK:  if (!req) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered status, read data and wait counter.
  always_comb begin
    stat_next    = '0;
    data_in_next = '0;
    cnt_next     = cnt_q;
    case (state)
      ST_IDLE: if (req) cnt_next = CNT_W'(WAIT_STATES);
      ST_WAIT: if (cnt_q != '0) cnt_next = cnt_q - CNT_W'(1);
      default: cnt_next = cnt_q;
    endcase
    if (next_state == ST_WAIT) begin
      stat_next = word_width'(3'b010);
    end else if (next_state == ST_ACK) begin
      if (commit) begin
        stat_next    = word_width'({err, 2'b11});
        data_in_next = rd_data;
      end else begin
        stat_next    = stat_q;
        data_in_next = data_in_q;
      end
    end
  end

  // Registered outputs, request latches and write counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      wcount_q  <= '0;
      stat_q    <= '0;
      data_in_q <= '0;
    end else begin
      cnt_q     <= cnt_next;
      stat_q    <= stat_next;
      data_in_q <= data_in_next;
      if (latch) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.data_out;
        we_q    <= we;
      end
      if (fb_we) wcount_q <= wcount_q + word_width'(1);
    end
  end

  // Frame buffer storage; contents survive reset, but a write pending under reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && fb_we) mem[fb_idx] <= wdata_q;
  end

  // VGA port: read-before-write on a same-index collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_data <= '0;
    end else begin
      pix_data <= mem[pix_addr];
    end
  end

  assign bus.mobo_stat = stat_q;
  assign bus.data_in   = data_in_q;

endmodule
